// File: rtl/synq_pkg.sv
// Shared definitions for the dual-product dot unit: FSM states,
// default operand width and the shift-add iteration count.
package synq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } synq_state_t;

  localparam int SYNQ_WIDTH = 16;

  // One radix-2 shift-add step per multiplier bit.
  localparam int SYNQ_ITERS = SYNQ_WIDTH;

endpackage

// File: rtl/synq_shift_add_mul.sv
// Sequential unsigned WIDTH x WIDTH multiplier. i_start loads the operands
// and clears the product; each i_step pulse retires one multiplier bit.
// After WIDTH steps o_product holds the full 2*WIDTH-bit product.
module synq_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_start,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;

  // Load on start, otherwise add the shifted multiplicand when the current LSB is set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_product = r_prod;

endmodule

// File: rtl/synq_dot2_unit.sv
// Computes a*b + c*d with two concurrent shift-add multipliers, then
// saturates or wraps to WIDTH bits and hands the result off with a
// strobe/busy handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for input_STB; BUSY low
// S_MUL  | one shift-add step per edge on both products, counter 0..WIDTH-1
// S_ACC  | sum products, saturate/wrap, register result and raise output_STB
// S_OUT  | hold result until the consumer drops output_module_BUSY
module synq_dot2_unit
  import synq_pkg::*;
#(
  parameter int WIDTH    = SYNQ_WIDTH,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [WIDTH-1:0] input_c,
  input  logic [WIDTH-1:0] input_d,
  input  logic             input_STB,
  output logic             BUSY,
  output logic [WIDTH-1:0] output_result,
  output logic             output_ovf,
  output logic             output_STB,
  input  logic             output_module_BUSY
);

  // The default build takes the shared iteration count; other widths derive it.
  localparam int ITERS     = (WIDTH == SYNQ_WIDTH) ? SYNQ_ITERS : WIDTH;
  localparam int CW        = $clog2(ITERS + 1);
  localparam int LAST_ITER = ITERS - 1;

  synq_state_t        r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_out_stb;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf;

  logic               w_start;
  logic               w_step;
  logic [2*WIDTH-1:0] w_prod_ab;
  logic [2*WIDTH-1:0] w_prod_cd;
  logic [2*WIDTH:0]   w_sum;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_result;

  assign w_start = (r_state == S_IDLE) && input_STB;
  assign w_step  = (r_state == S_MUL);

  synq_shift_add_mul #(.WIDTH(WIDTH)) u_mul_ab (
    .clk       (clk),
    .resetn    (resetn),
    .i_start   (w_start),
    .i_step    (w_step),
    .i_a       (input_a),
    .i_b       (input_b),
    .o_product (w_prod_ab)
  );

  synq_shift_add_mul #(.WIDTH(WIDTH)) u_mul_cd (
    .clk       (clk),
    .resetn    (resetn),
    .i_start   (w_start),
    .i_step    (w_step),
    .i_a       (input_c),
    .i_b       (input_d),
    .o_product (w_prod_cd)
  );

  // Extra sum bit keeps the carry out of the two full-width products.
  assign w_sum = {1'b0, w_prod_ab} + {1'b0, w_prod_cd};
  assign w_ovf = |w_sum[2*WIDTH:WIDTH];

  // Clamp or wrap the sum down to the result width.
  always_comb begin
    w_result = w_sum[WIDTH-1:0];
    if ((SATURATE != 0) && w_ovf) begin
      w_result = '1;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_out_stb <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (input_STB) begin
            r_state <= S_MUL;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(LAST_ITER)) begin
            r_state <= S_ACC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACC: begin
          r_result  <= w_result;
          r_ovf     <= w_ovf;
          r_out_stb <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (!output_module_BUSY) begin
            r_out_stb <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY          = r_busy;
  assign output_STB    = r_out_stb;
  assign output_result = r_result;
  assign output_ovf    = r_ovf;

endmodule
